// File: rtl/core_pkg.sv
// Shared core types: instruction/address widths and the fetch-queue entry layout.
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] instr_addr;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(input logic [XLEN-1:0] addr, input logic [ILEN-1:0] instr);
        fq_entry_t e;
        e.instr_addr = addr;
        e.instr      = instr;
        return e;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers (with wrap bit) and occupancy counter for a power-of-two FIFO.
// Flush has priority: the write pointer snaps back to the read pointer.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count,
    output logic [PW-2:0] wr_idx,
    output logic [PW-2:0] rd_idx
);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] count_reg, count_next;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = rd_ptr_reg;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + PW'(1);
                2'b01:   count_next = count_reg - PW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]) &&
                    (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]);
    assign count  = count_reg;
    assign wr_idx = wr_ptr_reg[PW-2:0];
    assign rd_idx = rd_ptr_reg[PW-2:0];

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead instruction buffer between fetch and decode with one-cycle flush.
// Optional FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when the queue is empty.
module fetch_queue #(
    parameter int XLEN         = core_pkg::XLEN,
    parameter int ILEN         = core_pkg::ILEN,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr_addr,
    input  logic [ILEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr_addr,
    output logic [ILEN-1:0] out_instr,
    output logic [CW-1:0]   count,
    output logic            afull
);

    import core_pkg::*;

    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [CW-2:0] wr_idx;
    logic [CW-2:0] rd_idx;
    fq_entry_t     head;

    // Storage is deliberately unreset; head data is only meaningful while out_valid is high.
    fq_entry_t mem [DEPTH];

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .wr_idx (wr_idx),
        .rd_idx (rd_idx)
    );

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= make_entry(in_instr_addr, in_instr);
    end

    assign head     = mem[rd_idx];
    assign in_ready = !full;
    assign afull    = (count >= AFULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // An idle queue hands the incoming instruction straight to decode without storing it.
    assign bypass         = empty && in_valid && out_ready && !flush;
    assign out_valid      = (!empty || in_valid) && !flush;
    assign out_instr_addr = empty ? in_instr_addr : head.instr_addr;
    assign out_instr      = empty ? in_instr      : head.instr;
    assign push           = in_valid && in_ready && !flush && !bypass;
    assign pop            = out_valid && out_ready && !empty;
`else
    assign out_valid      = !empty && !flush;
    assign out_instr_addr = head.instr_addr;
    assign out_instr      = head.instr;
    assign push           = in_valid && in_ready && !flush;
    assign pop            = out_valid && out_ready;
`endif

endmodule
